// File: rtl/mem_pkg.sv
// mem_pkg: shared L1 refill constants, FSM state encoding and owner encoding
package mem_pkg;
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  localparam int LINE_BYTES = 128;
  localparam int BEATS = 16;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester arbiter, round-robin with LINE_FILL_RR_EN, else data-side fixed priority
// Ports: clk/clr_n/i_en (round-robin build only; i_en = grant taken this cycle),
//        i_ireq/i_dreq instruction/data requests, o_gnt grant (0 = instruction, 1 = data)
module rr_arb2 import mem_pkg::*; (
`ifdef LINE_FILL_RR_EN
  input  logic clk,
  input  logic clr_n,
  input  logic i_en,
`endif
  input  logic i_ireq,
  input  logic i_dreq,
  output logic o_gnt
);
`ifdef LINE_FILL_RR_EN
  logic r_last;
  // reset as if data was granted last so the instruction side wins the first tie
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) r_last <= OWN_D;
    else if (i_en) r_last <= o_gnt;
  always_comb o_gnt = (i_ireq & i_dreq) ? ~r_last : i_dreq;
`else
  logic w_unused;
  always_comb w_unused = i_ireq;
  always_comb o_gnt = i_dreq;
`endif
endmodule

// File: rtl/line_fill_arb.sv
// line_fill_arb: L1 line refill controller; arbitrates I/D misses, fetches 16 beats, returns the line
// Ports: clk, clr_n (async active-low); i_addr/i_rd/i_dv and d_addr/d_rd/d_dv requester sides;
//        line assembled line; mem_addr/mem_rd/mem_rdata/mem_ack beat memory port.
// Build option: LINE_FILL_RR_EN selects round-robin arbitration (default: data side wins ties).
module line_fill_arb import mem_pkg::*; #(
  parameter int LINE_W = 1024,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [63:0]       i_addr,
  input  logic              i_rd,
  output logic              i_dv,
  input  logic [63:0]       d_addr,
  input  logic              d_rd,
  output logic              d_dv,
  output logic [LINE_W-1:0] line,
  output logic [63:0]       mem_addr,
  output logic              mem_rd,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  localparam logic [63:0] LINE_MASK = ~64'(LINE_BYTES - 1);
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_owner;
  logic [63:0]       r_base;
  logic [LINE_W-1:0] r_line;
  logic              r_i_dv, r_d_dv, r_mem_rd;
  logic [63:0]       r_mem_addr;
  logic              w_req, w_gnt;
  logic [63:0]       w_addr;
  logic [CNT_W-1:0]  w_nxt;
  always_comb begin
    w_req  = i_rd | d_rd;
    w_addr = w_gnt ? d_addr : i_addr;
    w_nxt  = r_cnt + 1'b1;
  end
  rr_arb2 u_arb (
`ifdef LINE_FILL_RR_EN
    .clk   (clk),
    .clr_n (clr_n),
    .i_en  (r_state == IDLE && w_req),
`endif
    .i_ireq(i_rd),
    .i_dreq(d_rd),
    .o_gnt (w_gnt)
  );
  // mem_addr is registered one beat ahead so it is base + 8*cnt in every FILL cycle
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_owner    <= OWN_I;
      r_base     <= '0;
      r_line     <= '0;
      r_i_dv     <= 1'b0;
      r_d_dv     <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_req) begin
          r_owner    <= w_gnt;
          r_base     <= w_addr & LINE_MASK;
          r_mem_addr <= w_addr & LINE_MASK;
          r_cnt      <= '0;
          r_mem_rd   <= 1'b1;
          r_state    <= FILL;
        end
        FILL: if (mem_ack) begin
          r_line[BEAT_W*int'(r_cnt) +: BEAT_W] <= mem_rdata;
          r_cnt      <= w_nxt;
          r_mem_addr <= r_base | {{(64-CNT_W-3){1'b0}}, w_nxt, 3'b000};
          if (r_cnt == CNT_W'(BEATS - 1)) begin
            r_state  <= DONE;
            r_mem_rd <= 1'b0;
            // an owner that has dropped rd abandoned the request and gets no dv
            r_i_dv   <= (r_owner == OWN_I) & i_rd;
            r_d_dv   <= (r_owner == OWN_D) & d_rd;
          end
        end
        DONE: begin
          r_i_dv  <= 1'b0;
          r_d_dv  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  always_comb begin
    i_dv     = r_i_dv;
    d_dv     = r_d_dv;
    line     = r_line;
    mem_rd   = r_mem_rd;
    mem_addr = r_mem_addr;
  end
endmodule

// File: tb/tb_line_fill_arb.sv
// tb_line_fill_arb: directed + randomized checks of line_fill_arb against a transaction-level model
module tb_line_fill_arb;
  logic          clk = 1'b0, clr_n = 1'b0;
  logic [63:0]   i_addr = '0, d_addr = '0, mem_addr, mem_rdata = '0;
  logic          i_rd = 1'b0, d_rd = 1'b0, i_dv, d_dv, mem_rd, mem_ack = 1'b0;
  logic [1023:0] line;
  int            n_cmp = 0, n_err = 0, lat;
  logic [63:0]   ia, da, b0;
  localparam logic [63:0] M = ~64'h7F;

  always #5 clk = ~clk;

  line_fill_arb dut (
    .clk(clk), .clr_n(clr_n),
    .i_addr(i_addr), .i_rd(i_rd), .i_dv(i_dv),
    .d_addr(d_addr), .d_rd(d_rd), .d_dv(d_dv),
    .line(line), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    step;
    chk("idle_rd", mem_rd, 0);
    chk("idle_dv", {i_dv, d_dv}, 0);
  endtask

  // Called in the IDLE cycle whose request should win; runs through the DONE cycle.
  // mode: 0 ack always, 1 ack on even cycles, 2 random ack. abandon: beat count at which owner drops rd.
  task automatic fill(input bit side, input logic [63:0] base, input int mode, input int abandon,
                      output int l, output logic [63:0] first);
    logic [63:0] eb [16];
    int k = 0, cyc = 0;
    bit ack;
    while (k < 16 && cyc < 200) begin
      step;
      cyc++;
      chk("fill_rd", mem_rd, 1);
      chk("fill_addr", mem_addr, base + 64'(8 * k));
      chk("fill_dv", {i_dv, d_dv}, 0);
      ack = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      mem_ack = ack;
      mem_rdata = {$urandom, $urandom};
      if (ack) begin
        eb[k] = mem_rdata;
        k++;
        if (k == abandon) begin
          if (side) d_rd = 1'b0;
          else i_rd = 1'b0;
        end
      end
    end
    chk("fill_beats", k, 16);
    step;
    l = cyc + 1;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = '1;
    chk("done_rd", mem_rd, 0);
    chk("done_dv", {i_dv, d_dv}, abandon > 16 ? (side ? 2'b01 : 2'b10) : 2'b00);
    for (int i = 0; i < 16; i++) chk($sformatf("line_beat%0d", i), line[64*i +: 64], eb[i]);
    first = eb[0];
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd", mem_rd, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_dv", {i_dv, d_dv}, 0);
    chk("rst_line", 64'(|line), 0);
    @(negedge clk) clr_n = 1'b1;
    mem_ack = 1'b1;
    idle;
    mem_ack = 1'b0;
    // single instruction miss, ack tied high
    i_addr = 64'h1000_0044;
    i_rd = 1'b1;
    fill(0, 64'h1000_0000, 0, 99, lat, b0);
    chk("lat_single", lat, 17);
    i_rd = 1'b0;
    idle;
    chk("line_hold", line[63:0], b0);
    // wait states every other cycle
    ia = {$urandom, $urandom};
    i_addr = ia;
    i_rd = 1'b1;
    fill(0, ia & M, 1, 99, lat, b0);
    chk("lat_wait", lat, 33);
    i_rd = 1'b0;
    idle;
    // simultaneous requests
    ia = {$urandom, $urandom};
    da = {$urandom, $urandom};
    i_addr = ia;
    d_addr = da;
    i_rd = 1'b1;
    d_rd = 1'b1;
`ifdef LINE_FILL_RR_EN
    fill(0, ia & M, 0, 99, lat, b0);
    chk("lat_rr0", lat, 17);
    ia = {$urandom, $urandom};
    i_addr = ia;
    idle;
    fill(1, da & M, 0, 99, lat, b0);
    chk("lat_rr1", lat, 17);
    d_rd = 1'b0;
    idle;
    fill(0, ia & M, 0, 99, lat, b0);
    chk("lat_rr2", lat, 17);
    i_rd = 1'b0;
    idle;
`else
    fill(1, da & M, 0, 99, lat, b0);
    chk("lat_fp0", lat, 17);
    d_rd = 1'b0;
    idle;
    fill(0, ia & M, 0, 99, lat, b0);
    chk("lat_fp1", lat, 17);
    i_rd = 1'b0;
    idle;
`endif
    // abandon at beat 5, then normal requests
    da = {$urandom, $urandom};
    d_addr = da;
    d_rd = 1'b1;
    fill(1, da & M, 2, 5, lat, b0);
    idle;
    ia = {$urandom, $urandom};
    i_addr = ia;
    i_rd = 1'b1;
    fill(0, ia & M, 2, 99, lat, b0);
    i_rd = 1'b0;
    idle;
    // reset mid-fill
    ia = {$urandom, $urandom};
    i_addr = ia;
    i_rd = 1'b1;
    repeat (9) begin
      step;
      mem_ack = 1'b1;
      mem_rdata = {$urandom, $urandom};
    end
    chk("pre_rst_rd", mem_rd, 1);
    #2 clr_n = 1'b0;
    #1;
    chk("async_rst_rd", mem_rd, 0);
    chk("async_rst_addr", mem_addr, 0);
    chk("async_rst_dv", {i_dv, d_dv}, 0);
    chk("async_rst_line", 64'(|line), 0);
    i_rd = 1'b0;
    mem_ack = 1'b0;
    step;
    chk("hold_rst_rd", mem_rd, 0);
    @(negedge clk) clr_n = 1'b1;
    ia = {$urandom, $urandom};
    i_addr = ia;
    i_rd = 1'b1;
    fill(0, ia & M, 0, 99, lat, b0);
    chk("lat_after_rst", lat, 17);
    i_rd = 1'b0;
    idle;
    // randomized single-side fills
    for (int n = 0; n < 6; n++) begin
      automatic bit s = 1'($urandom_range(0, 1));
      automatic int md = $urandom_range(0, 2);
      automatic logic [63:0] a = {$urandom, $urandom};
      if (s) begin d_addr = a; d_rd = 1'b1; end
      else begin i_addr = a; i_rd = 1'b1; end
      fill(s, a & M, md, 99, lat, b0);
      if (md == 0) chk("lat_rand", lat, 17);
      i_rd = 1'b0;
      d_rd = 1'b0;
      idle;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
